// File: rtl/biquad_pkg.sv
// biquad_pkg: scheduler state encoding, biquad tap indices and
// the passthrough coefficient reset value shared by the cascade files.
package biquad_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC,
        S_WAIT,
        S_WB,
        S_OUT
    } state_e;

    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;
    localparam int         NTAP   = 5;

    // B0 = 1.0 in Q(.frac), every other tap zero: each section is a wire
    function automatic longint coef_reset(input int tap, input int frac);
        return (tap == int'(TAP_B0)) ? (longint'(1) << frac) : longint'(0);
    endfunction

endpackage

// File: rtl/biquad_coef_bank.sv
// biquad_coef_bank: NTAP*NSEC coefficient registers, gated write port,
// combinational read addressed by (section, tap).
module biquad_coef_bank
    import biquad_pkg::*;
#(
    parameter int Wc   = 18,
    parameter int FRAC = 16,
    parameter int NSEC = 4,
    parameter int AW   = $clog2(NTAP * NSEC),
    parameter int SW   = (NSEC > 1) ? $clog2(NSEC) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic signed [Wc-1:0] wdata_i,
    input  logic [SW-1:0]        rd_sec_i,
    input  logic [2:0]           rd_tap_i,
    output logic signed [Wc-1:0] rd_data_o
);

    localparam int N = NTAP * NSEC;

    logic signed [Wc-1:0] mem_q [N];
    logic [AW:0]          rd_idx;

    assign rd_idx    = (AW+1)'(int'(rd_sec_i) * NTAP + int'(rd_tap_i));
    assign rd_data_o = (rd_idx < (AW+1)'(N)) ? mem_q[rd_idx[AW-1:0]] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= Wc'(coef_reset(i % NTAP, FRAC));
            end
        end else if (we_i && (int'(waddr_i) < N)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/biquad_mac_sched.sv
// biquad_mac_sched: runs an NSEC-section DF-I biquad cascade on one shared
// external MULT_ACC. Define BIQUAD_SAT_EN to saturate section outputs.
module biquad_mac_sched
    import biquad_pkg::*;
#(
    parameter int Win  = 24,
    parameter int Wc   = 18,
    parameter int Wout = 48,
    parameter int FRAC = 16,
    parameter int NSEC = 4
) (
    input  logic                          ic_clk,
    input  logic                          ic_rst_n,
    input  logic signed [Win-1:0]         id_din,
    input  logic                          ic_din_valid,
    output logic                          oc_din_ready,
    output logic signed [Win-1:0]         od_dout,
    output logic                          oc_dout_valid,
    input  logic                          ic_coef_we,
    input  logic [$clog2(5*NSEC)-1:0]     id_coef_addr,
    input  logic signed [Wc-1:0]          id_coef_wdata,
    output logic                          oc_busy,
    output logic signed [Win-1:0]         od_mac_din,
    output logic signed [Wc-1:0]          od_mac_coef,
    output logic                          oc_mac_ce,
    output logic                          oc_mac_rst,
    output logic                          oc_mac_neg,
    input  logic signed [Wout-1:0]        id_mac_dout
);

    localparam int AW = $clog2(5 * NSEC);
    localparam int SW = (NSEC > 1) ? $clog2(NSEC) : 1;

    state_e                st_q;
    logic [SW-1:0]         s_q;
    logic [2:0]            k_q;
    logic signed [Win-1:0] x_q;
    logic signed [Win-1:0] x1_q [NSEC];
    logic signed [Win-1:0] x2_q [NSEC];
    logic signed [Win-1:0] y1_q [NSEC];
    logic signed [Win-1:0] y2_q [NSEC];
    logic signed [Wout-1:0] acc_q;
    logic signed [Win-1:0] dout_q;
    logic                  valid_q;
    logic                  ce_q, rst_q, neg_q;
    logic signed [Win-1:0] mdin_q;
    logic signed [Wc-1:0]  mcoef_q;

    logic [2:0]             k_nxt;
    logic signed [Wc-1:0]   coef_rd;
    logic signed [Win-1:0]  opnd;
    logic signed [Wout-1:0] sh;
    logic signed [Win-1:0]  y_w;
    logic                   unused_sh;

    // operands are registered, so look up the tap the MAC uses next cycle
    assign k_nxt = (st_q == S_MAC) ? k_q + 3'd1 : TAP_B0;

    biquad_coef_bank #(
        .Wc   (Wc),
        .FRAC (FRAC),
        .NSEC (NSEC),
        .AW   (AW),
        .SW   (SW)
    ) u_bank (
        .clk_i     (ic_clk),
        .rst_ni    (ic_rst_n),
        .we_i      (ic_coef_we && (st_q == S_IDLE)),
        .waddr_i   (id_coef_addr),
        .wdata_i   (id_coef_wdata),
        .rd_sec_i  (s_q),
        .rd_tap_i  (k_nxt),
        .rd_data_o (coef_rd)
    );

    always_comb begin
        opnd = '0;
        case (k_nxt)
            TAP_B0:  opnd = x_q;
            TAP_B1:  opnd = x1_q[s_q];
            TAP_B2:  opnd = x2_q[s_q];
            TAP_A1:  opnd = y1_q[s_q];
            TAP_A2:  opnd = y2_q[s_q];
            default: opnd = '0;
        endcase
    end

    assign sh        = acc_q >>> FRAC;
    assign unused_sh = ^sh[Wout-1:Win];

`ifdef BIQUAD_SAT_EN
    localparam logic signed [Wout-1:0] YMAX =
        Wout'((longint'(1) <<< (Win - 1)) - 1);
    localparam logic signed [Wout-1:0] YMIN =
        Wout'(-(longint'(1) <<< (Win - 1)));

    always_comb begin
        if (sh > YMAX)      y_w = YMAX[Win-1:0];
        else if (sh < YMIN) y_w = YMIN[Win-1:0];
        else                y_w = sh[Win-1:0];
    end
`else
    assign y_w = sh[Win-1:0];
`endif

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            st_q    <= S_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            x_q     <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ce_q    <= 1'b0;
            rst_q   <= 1'b0;
            neg_q   <= 1'b0;
            mdin_q  <= '0;
            mcoef_q <= '0;
            for (int i = 0; i < NSEC; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            ce_q    <= 1'b0;
            rst_q   <= 1'b0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
            mdin_q  <= '0;
            mcoef_q <= '0;
            unique case (st_q)
                S_IDLE: begin
                    if (ic_din_valid) begin
                        x_q   <= id_din;
                        s_q   <= '0;
                        rst_q <= 1'b1;
                        st_q  <= S_CLR;
                    end
                end
                S_CLR: begin
                    k_q     <= TAP_B0;
                    ce_q    <= 1'b1;
                    mdin_q  <= opnd;
                    mcoef_q <= coef_rd;
                    st_q    <= S_MAC;
                end
                S_MAC: begin
                    if (k_q == TAP_A2) begin
                        st_q <= S_WAIT;
                    end else begin
                        k_q     <= k_nxt;
                        ce_q    <= 1'b1;
                        neg_q   <= (k_nxt >= TAP_A1);
                        mdin_q  <= opnd;
                        mcoef_q <= coef_rd;
                    end
                end
                S_WAIT: begin
                    acc_q <= id_mac_dout;
                    st_q  <= S_WB;
                end
                S_WB: begin
                    x2_q[s_q] <= x1_q[s_q];
                    x1_q[s_q] <= x_q;
                    y2_q[s_q] <= y1_q[s_q];
                    y1_q[s_q] <= y_w;
                    x_q       <= y_w;
                    if (s_q == SW'(NSEC - 1)) begin
                        dout_q  <= y_w;
                        valid_q <= 1'b1;
                        st_q    <= S_OUT;
                    end else begin
                        s_q   <= s_q + SW'(1);
                        rst_q <= 1'b1;
                        st_q  <= S_CLR;
                    end
                end
                S_OUT: begin
                    st_q <= S_IDLE;
                end
                default: begin
                    st_q <= S_IDLE;
                end
            endcase
        end
    end

    assign oc_din_ready  = (st_q == S_IDLE);
    assign oc_busy       = (st_q != S_IDLE);
    assign od_dout       = dout_q;
    assign oc_dout_valid = valid_q;
    assign oc_mac_ce     = ce_q;
    assign oc_mac_rst    = rst_q;
    assign oc_mac_neg    = neg_q;
    assign od_mac_din    = mdin_q;
    assign od_mac_coef   = mcoef_q;

endmodule

// File: tb/tb_biquad_mac_sched.sv
// tb_biquad_mac_sched: directed bench with a behavioural MULT_ACC and an
// expected-output queue for the biquad cascade scheduler.
module tb_biquad_mac_sched;

    localparam int Win  = 24;
    localparam int Wc   = 18;
    localparam int Wout = 48;
    localparam int FRAC = 16;
    localparam int NSEC = 4;
    localparam int AW   = $clog2(5 * NSEC);
    localparam int LAT  = 8 * NSEC + 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic signed [Win-1:0]  din = '0;
    logic                   din_valid = 1'b0;
    logic                   din_ready;
    logic signed [Win-1:0]  dout;
    logic                   dout_valid;
    logic                   coef_we = 1'b0;
    logic [AW-1:0]          coef_addr = '0;
    logic signed [Wc-1:0]   coef_wdata = '0;
    logic                   busy;
    logic signed [Win-1:0]  mac_din;
    logic signed [Wc-1:0]   mac_coef;
    logic                   mac_ce, mac_rst, mac_neg;
    logic signed [Wout-1:0] mac_acc;

    int     nchk = 0;
    int     nfail = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    longint prod;
    longint sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb prod = longint'(mac_din) * longint'(mac_coef);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       mac_acc <= '0;
        else if (mac_rst) mac_acc <= '0;
        else if (mac_ce)  mac_acc <= mac_neg ? mac_acc - Wout'(prod)
                                             : mac_acc + Wout'(prod);
    end

    biquad_mac_sched #(
        .Win (Win), .Wc (Wc), .Wout (Wout), .FRAC (FRAC), .NSEC (NSEC)
    ) dut (
        .ic_clk        (clk),
        .ic_rst_n      (rst_n),
        .id_din        (din),
        .ic_din_valid  (din_valid),
        .oc_din_ready  (din_ready),
        .od_dout       (dout),
        .oc_dout_valid (dout_valid),
        .ic_coef_we    (coef_we),
        .id_coef_addr  (coef_addr),
        .id_coef_wdata (coef_wdata),
        .oc_busy       (busy),
        .od_mac_din    (mac_din),
        .od_mac_coef   (mac_coef),
        .oc_mac_ce     (mac_ce),
        .oc_mac_rst    (mac_rst),
        .oc_mac_neg    (mac_neg),
        .id_mac_dout   (mac_acc)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        din_valid = 1'b0;
        coef_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_coef(input int addr, input int val);
        @(negedge clk);
        coef_we = 1'b1;
        coef_addr = AW'(addr);
        coef_wdata = Wc'(val);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic start_sample(input int d, input longint exp, input bit push);
        @(negedge clk);
        chk("ready_before_accept", din_ready, 1);
        din = Win'(d);
        din_valid = 1'b1;
        acc_cyc = cyc;
        if (push) sb.push_back(exp);
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        bit     got;
        longint exp;
        got = 1'b0;
        while (!got && (cyc < acc_cyc + 100)) begin
            if (dout_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_valid_seen"}, got, 1);
        exp = (sb.size() > 0) ? sb.pop_front() : longint'(0);
        if (got) begin
            chk({tag, "_latency"}, cyc - acc_cyc, LAT);
            chk({tag, "_dout"}, dout, exp);
            @(negedge clk);
            chk({tag, "_pulse_end"}, dout_valid, 0);
            chk({tag, "_ready_back"}, din_ready, 1);
        end
    endtask

    task automatic run(input string tag, input int d, input longint exp);
        start_sample(d, exp, 1'b1);
        wait_out(tag);
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", din_ready, 1);
        chk("rst_mac_ce", mac_ce, 0);
        chk("rst_mac_rst", mac_rst, 0);
        chk("rst_mac_neg", mac_neg, 0);
        chk("rst_mac_din", mac_din, 0);
        chk("rst_mac_coef", mac_coef, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run("pass_1000", 1000, 1000);

        write_coef(0, 32768);
        run("gain_pos", 1000, 500);
        run("gain_neg", -1000, -500);

        do_reset();
        write_coef(0, 0);
        write_coef(1, 65536);
        run("delay_0", 100, 0);
        run("delay_1", 200, 100);
        run("delay_2", 300, 200);

        do_reset();
        write_coef(0, 65536);
        write_coef(3, -32768);
        run("fb_0", 1000, 1000);
        run("fb_1", 0, 500);
        run("fb_2", 0, 250);

        do_reset();
        write_coef(0, 131071);
`ifdef BIQUAD_SAT_EN
        run("ovf_sat", 6000000, 8388607);
`else
        run("ovf_wrap", 6000000, -4777308);
`endif

        do_reset();
        start_sample(1234, 1234, 1'b1);
        chk("busy_during_run", busy, 1);
        write_coef(0, 0);
        wait_out("busy_write");
        run("busy_write_after", 777, 777);

        start_sample(555, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_ce_k2", mac_ce, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_ce_cleared", mac_ce, 0);
        chk("mid_busy_cleared", busy, 0);
        chk("mid_ready", din_ready, 1);
        chk("mid_dout", dout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (dout_valid === 1'b1) seen = 1'b1;
        end
        chk("mid_no_valid", seen, 0);
        chk("mid_ready_after", din_ready, 1);
        run("mid_passthrough", 4321, 4321);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule
